// File: rtl/qed_pkg.sv
// Shared constants and types for the QED instruction duplicator.
// Opcodes, NOP encoding, default buffer depth and the FSM state type live here.
package qed_pkg;

  localparam int unsigned QED_DEPTH_DEFAULT = 8;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [31:0] QED_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_ORIG = 1'b0,
    ST_DUP  = 1'b1
  } qed_state_e;

  typedef struct packed {
    logic rd;
    logic rs1;
    logic rs2;
  } reg_use_t;

  // Which register fields an opcode actually reads or writes.
  function automatic reg_use_t reg_use(input logic [6:0] opc);
    reg_use_t u;
    case (opc)
      OPC_OP:     u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b1};
      OPC_OP_IMM: u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
      OPC_LOAD:   u = '{rd: 1'b1, rs1: 1'b1, rs2: 1'b0};
      OPC_STORE:  u = '{rd: 1'b0, rs1: 1'b1, rs2: 1'b1};
      OPC_LUI:    u = '{rd: 1'b1, rs1: 1'b0, rs2: 1'b0};
      default:    u = '{rd: 1'b0, rs1: 1'b0, rs2: 1'b0};
    endcase
    return u;
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/qed_remap.sv
// Combinational legalizer and register remapper: originals use x0-x15, duplicates
// use the mirrored x16-x31 so both copies can run side by side without interference.
module qed_remap
  import qed_pkg::*;
(
  input  logic [31:0] in_instr,
  output logic [31:0] legal_instr,
  output logic [31:0] dup_instr
);

  reg_use_t in_use_s;
  reg_use_t legal_use_s;
  logic     bad_reg_s;

  // Legalize: unknown opcode or any used register in the upper half becomes NOP.
  always_comb begin
    in_use_s  = reg_use(in_instr[6:0]);
    bad_reg_s = (in_use_s.rd  & in_instr[11]) |
                (in_use_s.rs1 & in_instr[19]) |
                (in_use_s.rs2 & in_instr[24]);
    if (opc_legal(in_instr[6:0]) && !bad_reg_s) begin
      legal_instr = in_instr;
    end else begin
      legal_instr = QED_NOP;
    end
  end

  // Remap: set bit 4 of every used nonzero register field; x0 stays x0.
  always_comb begin
    legal_use_s = reg_use(legal_instr[6:0]);
    dup_instr   = legal_instr;
    if (legal_use_s.rd && (legal_instr[11:7] != 5'd0)) begin
      dup_instr[11] = 1'b1;
    end else begin
      dup_instr[11] = legal_instr[11];
    end
    if (legal_use_s.rs1 && (legal_instr[19:15] != 5'd0)) begin
      dup_instr[19] = 1'b1;
    end else begin
      dup_instr[19] = legal_instr[19];
    end
    if (legal_use_s.rs2 && (legal_instr[24:20] != 5'd0)) begin
      dup_instr[24] = 1'b1;
    end else begin
      dup_instr[24] = legal_instr[24];
    end
  end

endmodule

// File: rtl/qed_instr_dup.sv
// QED instruction duplicator: passes legalized originals to the core while buffering
// their remapped copies, then replays the copies in order and pulses QED_CHECK.
module qed_instr_dup
  import qed_pkg::*;
#(
  parameter int unsigned DEPTH = QED_DEPTH_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] QED_IN_INSTR,
  input  logic        QED_EXEC_DUP,
  input  logic        ADV,
  output logic [31:0] INSTR,
  output logic        QED_IS_DUP,
  output logic [3:0]  QED_CNT,
  output logic        QED_CHECK
);

  localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_CNT = 4'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  qed_state_e    state_r, state_nxt_s;
  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [3:0]    cnt_r;
  logic          check_r, check_nxt_s;
  logic          push_s, pop_s;
  logic [31:0]   legal_s, dup_s;

  qed_remap u_remap (
    .in_instr    (QED_IN_INSTR),
    .legal_instr (legal_s),
    .dup_instr   (dup_s)
  );

  // Next-state logic; push only in ORIG, pop only in DUP, so they never coincide.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    check_nxt_s = 1'b0;
    case (state_r)
      ST_ORIG: begin
        if (ADV && (cnt_r != DEPTH_CNT)) begin
          push_s = 1'b1;
          if (((cnt_r + 4'd1) == DEPTH_CNT) || QED_EXEC_DUP) begin
            state_nxt_s = ST_DUP;
          end else begin
            state_nxt_s = ST_ORIG;
          end
        end else begin
          state_nxt_s = ST_ORIG;
        end
      end
      ST_DUP: begin
        if (ADV && (cnt_r != 4'd0)) begin
          pop_s = 1'b1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = ST_ORIG;
            check_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DUP;
          end
        end else begin
          state_nxt_s = ST_DUP;
        end
      end
      default: state_nxt_s = ST_ORIG;
    endcase
  end

  // Control state, occupancy and wrapping pointers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r  <= ST_ORIG;
      cnt_r    <= 4'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      check_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      check_r <= check_nxt_s;
      if (push_s) begin
        cnt_r    <= cnt_r + 4'd1;
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? '0 : wr_ptr_r + PW'(1);
      end else if (pop_s) begin
        cnt_r    <= cnt_r - 4'd1;
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? '0 : rd_ptr_r + PW'(1);
      end
    end
  end

  // Duplicate storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= dup_s;
    end
  end

  // Output selection.
  always_comb begin
    if (!RESET) begin
      INSTR = QED_NOP;
    end else if (state_r == ST_DUP) begin
      INSTR = mem_r[rd_ptr_r];
    end else begin
      INSTR = legal_s;
    end
    QED_IS_DUP = RESET && (state_r == ST_DUP);
    QED_CNT    = cnt_r;
    QED_CHECK  = check_r;
  end

endmodule

// File: tb/tb_qed_instr_dup.sv
// Directed self-checking bench for qed_instr_dup with hand-computed expectations.
module tb_qed_instr_dup;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] QED_IN_INSTR;
  logic        QED_EXEC_DUP;
  logic        ADV;
  logic [31:0] INSTR;
  logic        QED_IS_DUP;
  logic [3:0]  QED_CNT;
  logic        QED_CHECK;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  qed_instr_dup #(.DEPTH(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .QED_IN_INSTR (QED_IN_INSTR),
    .QED_EXEC_DUP (QED_EXEC_DUP),
    .ADV          (ADV),
    .INSTR        (INSTR),
    .QED_IS_DUP   (QED_IS_DUP),
    .QED_CNT      (QED_CNT),
    .QED_CHECK    (QED_CHECK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    RESET = 1'b0; ADV = 1'b0; QED_EXEC_DUP = 1'b0; QED_IN_INSTR = 32'h0051_0093;
    tick(); tick(); #1;
    checks++; if (INSTR !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", INSTR, NOP); end
    checks++; if (QED_IS_DUP !== 1'b0) begin failures++; $display("FAIL reset_isdup got=%b exp=0", QED_IS_DUP); end
    checks++; if (QED_CNT !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", QED_CNT); end
    checks++; if (QED_CHECK !== 1'b0) begin failures++; $display("FAIL reset_check got=%b exp=0", QED_CHECK); end
  endtask

  task automatic test_orig_addi();
    RESET = 1'b1; QED_IN_INSTR = 32'h0051_0093; ADV = 1'b1; QED_EXEC_DUP = 1'b1; #1;
    checks++; if (INSTR !== 32'h0051_0093) begin failures++; $display("FAIL addi_orig got=%h exp=00510093", INSTR); end
    checks++; if (QED_IS_DUP !== 1'b0) begin failures++; $display("FAIL addi_orig_isdup got=%b exp=0", QED_IS_DUP); end
    tick(); ADV = 1'b0; QED_EXEC_DUP = 1'b0; #1;
    checks++; if (INSTR !== 32'h0059_0893) begin failures++; $display("FAIL addi_dup got=%h exp=00590893", INSTR); end
    checks++; if (QED_IS_DUP !== 1'b1) begin failures++; $display("FAIL addi_dup_isdup got=%b exp=1", QED_IS_DUP); end
    checks++; if (QED_CNT !== 4'd1) begin failures++; $display("FAIL addi_dup_cnt got=%0d exp=1", QED_CNT); end
    ADV = 1'b1; tick(); ADV = 1'b0; #1;
    checks++; if (QED_CHECK !== 1'b1) begin failures++; $display("FAIL addi_check got=%b exp=1", QED_CHECK); end
    checks++; if (QED_CNT !== 4'd0) begin failures++; $display("FAIL addi_cnt_after got=%0d exp=0", QED_CNT); end
    checks++; if (QED_IS_DUP !== 1'b0) begin failures++; $display("FAIL addi_back_orig got=%b exp=0", QED_IS_DUP); end
    tick(); #1;
    checks++; if (QED_CHECK !== 1'b0) begin failures++; $display("FAIL addi_check_once got=%b exp=0", QED_CHECK); end
  endtask

  task automatic test_exec_dup_add();
    QED_EXEC_DUP = 1'b1; ADV = 1'b0; tick(); #1;
    checks++; if (QED_IS_DUP !== 1'b0 || QED_CNT !== 4'd0) begin failures++; $display("FAIL exec_empty_ignored isdup=%b cnt=%0d exp isdup=0 cnt=0", QED_IS_DUP, QED_CNT); end
    QED_EXEC_DUP = 1'b0; QED_IN_INSTR = 32'h0020_81B3; ADV = 1'b1; #1;
    checks++; if (INSTR !== 32'h0020_81B3) begin failures++; $display("FAIL add_orig got=%h exp=002081b3", INSTR); end
    tick(); ADV = 1'b0; QED_EXEC_DUP = 1'b1; tick(); #1;
    checks++; if (QED_IS_DUP !== 1'b0 || QED_CNT !== 4'd1) begin failures++; $display("FAIL exec_noadv_hold isdup=%b cnt=%0d exp isdup=0 cnt=1", QED_IS_DUP, QED_CNT); end
    QED_IN_INSTR = 32'h0051_0093; ADV = 1'b1; tick(); ADV = 1'b0; QED_EXEC_DUP = 1'b0; #1;
    checks++; if (QED_IS_DUP !== 1'b1) begin failures++; $display("FAIL add_dup_isdup got=%b exp=1", QED_IS_DUP); end
    checks++; if (INSTR !== 32'h0128_89B3) begin failures++; $display("FAIL add_dup got=%h exp=012889b3", INSTR); end
    checks++; if (QED_CNT !== 4'd2) begin failures++; $display("FAIL add_dup_cnt got=%0d exp=2", QED_CNT); end
    ADV = 1'b1; tick(); #1;
    checks++; if (INSTR !== 32'h0059_0893 || QED_CHECK !== 1'b0) begin failures++; $display("FAIL add_second got=%h check=%b exp=00590893 check=0", INSTR, QED_CHECK); end
    tick(); ADV = 1'b0; #1;
    checks++; if (QED_CHECK !== 1'b1 || QED_CNT !== 4'd0) begin failures++; $display("FAIL add_check check=%b cnt=%0d exp check=1 cnt=0", QED_CHECK, QED_CNT); end
  endtask

  task automatic test_illegal();
    logic [31:0] ill [3];
    ill[0] = 32'h0000_0073;  // ecall
    ill[1] = 32'h0020_8A33;  // add x20,x1,x2
    ill[2] = 32'h0008_0093;  // addi x1,x16,0
    ADV = 1'b0; QED_EXEC_DUP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      QED_IN_INSTR = ill[i]; #1;
      checks++; if (INSTR !== NOP) begin failures++; $display("FAIL illegal_%0d got=%h exp=%h", i, INSTR, NOP); end
    end
  endtask

  task automatic test_formats();
    logic [31:0] orig [4];
    logic [31:0] dup  [4];
    orig[0] = 32'hFFFF_F0B7; dup[0] = 32'hFFFF_F8B7;  // lui x1 (rs1 bits are immediate)
    orig[1] = 32'h0020_A823; dup[1] = 32'h0128_A823;  // sw x2,16(x1) (rd bits are immediate)
    orig[2] = 32'h0080_2303; dup[2] = 32'h0080_2B03;  // lw x6,8(x0)
    orig[3] = 32'h0000_0073; dup[3] = NOP;            // ecall
    for (int i = 0; i < 4; i++) begin
      QED_IN_INSTR = orig[i]; ADV = 1'b1; QED_EXEC_DUP = (i == 3); #1;
      checks++; if (INSTR !== ((i == 3) ? NOP : orig[i])) begin failures++; $display("FAIL fmt_orig_%0d got=%h", i, INSTR); end
      tick();
    end
    QED_EXEC_DUP = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (INSTR !== dup[i] || QED_IS_DUP !== 1'b1) begin failures++; $display("FAIL fmt_dup_%0d got=%h isdup=%b exp=%h", i, INSTR, QED_IS_DUP, dup[i]); end
      tick();
    end
    ADV = 1'b0; #1;
    checks++; if (QED_CHECK !== 1'b1) begin failures++; $display("FAIL fmt_check got=%b exp=1", QED_CHECK); end
  endtask

  task automatic test_full_batch();
    int pulses;
    QED_EXEC_DUP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      QED_IN_INSTR = (32'(i) << 20) | 32'h0001_0093; ADV = 1'b1; #1;
      checks++; if (INSTR !== ((32'(i) << 20) | 32'h0001_0093)) begin failures++; $display("FAIL full_orig_%0d got=%h", i, INSTR); end
      tick(); ADV = 1'b0; #1;
      checks++; if (QED_CNT !== 4'(i + 1) || QED_IS_DUP !== (i == 7)) begin failures++; $display("FAIL full_push_%0d cnt=%0d isdup=%b exp cnt=%0d", i, QED_CNT, QED_IS_DUP, i + 1); end
    end
    QED_IN_INSTR = 32'h0000_0073; QED_EXEC_DUP = 1'b1; ADV = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      checks++; if (INSTR !== 32'h0009_0893 || QED_CNT !== 4'd8 || QED_IS_DUP !== 1'b1) begin failures++; $display("FAIL hold_%0d instr=%h cnt=%0d isdup=%b exp=00090893 cnt=8", k, INSTR, QED_CNT, QED_IS_DUP); end
    end
    QED_EXEC_DUP = 1'b0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      ADV = 1'b1; #1;
      checks++; if (INSTR !== ((32'(i) << 20) | 32'h0009_0893)) begin failures++; $display("FAIL full_dup_%0d got=%h exp=%h", i, INSTR, (32'(i) << 20) | 32'h0009_0893); end
      tick(); #1;
      if (QED_CHECK === 1'b1) pulses++;
    end
    ADV = 1'b0; tick(); #1;
    if (QED_CHECK === 1'b1) pulses++;
    checks++; if (pulses != 1) begin failures++; $display("FAIL full_check_pulses got=%0d exp=1", pulses); end
    checks++; if (QED_CNT !== 4'd0 || QED_IS_DUP !== 1'b0) begin failures++; $display("FAIL full_end cnt=%0d isdup=%b exp cnt=0 isdup=0", QED_CNT, QED_IS_DUP); end
  endtask

  task automatic test_reset_mid_dup();
    for (int i = 0; i < 3; i++) begin
      QED_IN_INSTR = (32'(20 + i) << 20) | 32'h0001_0093; ADV = 1'b1; QED_EXEC_DUP = (i == 2);
      tick();
    end
    ADV = 1'b0; QED_EXEC_DUP = 1'b0; #1;
    checks++; if (QED_CNT !== 4'd3 || QED_IS_DUP !== 1'b1) begin failures++; $display("FAIL rst_setup cnt=%0d isdup=%b exp cnt=3 isdup=1", QED_CNT, QED_IS_DUP); end
    RESET = 1'b0; #1;
    checks++; if (INSTR !== NOP) begin failures++; $display("FAIL rst_low_instr got=%h exp=%h", INSTR, NOP); end
    tick(); RESET = 1'b1; QED_IN_INSTR = 32'h0071_0093; #1;
    checks++; if (QED_CNT !== 4'd0 || QED_IS_DUP !== 1'b0 || QED_CHECK !== 1'b0) begin failures++; $display("FAIL rst_mid_dup cnt=%0d isdup=%b check=%b exp 0 0 0", QED_CNT, QED_IS_DUP, QED_CHECK); end
    checks++; if (INSTR !== 32'h0071_0093) begin failures++; $display("FAIL rst_orig_instr got=%h exp=00710093", INSTR); end
    ADV = 1'b1; QED_EXEC_DUP = 1'b1; tick(); ADV = 1'b0; QED_EXEC_DUP = 1'b0; #1;
    checks++; if (INSTR !== 32'h0079_0893 || QED_CNT !== 4'd1) begin failures++; $display("FAIL rst_discard got=%h cnt=%0d exp=00790893 cnt=1", INSTR, QED_CNT); end
    ADV = 1'b1; tick(); ADV = 1'b0; #1;
    checks++; if (QED_CHECK !== 1'b1) begin failures++; $display("FAIL rst_final_check got=%b exp=1", QED_CHECK); end
  endtask

  initial begin
    test_reset();
    test_orig_addi();
    test_exec_dup_add();
    test_illegal();
    test_formats();
    test_full_batch();
    test_reset_mid_dup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
